// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and ecall-halt drain FSM.
// Optional macro ID_EX_WB_BYPASS_EN forwards the writeback port into captured source data.
module id_ex_stage #(
  parameter int CTRL_W       = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_pc,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [31:0]       dec_imm,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              dec_mem_read,
  input  logic              dec_reg_write,
  input  logic              dec_is_halt,
  input  logic [31:0]       rs1_dout,
  input  logic [31:0]       rs2_dout,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              wb_reg_write,
  input  logic              flush,
  output logic              stall_if_id,
  output logic              id_ex_valid,
  output logic              id_ex_mem_read,
  output logic              id_ex_reg_write,
  output logic [31:0]       id_ex_pc,
  output logic [31:0]       id_ex_rs1_data,
  output logic [31:0]       id_ex_rs2_data,
  output logic [31:0]       id_ex_imm,
  output logic [4:0]        id_ex_rs1,
  output logic [4:0]        id_ex_rs2,
  output logic [4:0]        id_ex_rd,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              halted,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             take;
  logic [31:0]      rs1_sel, rs2_sel;

  // Handshake: the decode slot is accepted on a posedge only when
  // if_id_valid=1 and stall_if_id=0 (and no flush); otherwise a bubble enters ID/EX.
  always_comb begin
    load_use = if_id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rd != 5'd0) &
               ((dec_use_rs1 & (dec_rs1 == id_ex_rd)) |
                (dec_use_rs2 & (dec_rs2 == id_ex_rd)));
  end

  assign stall_if_id = load_use | (state_q != ST_RUN);
  assign take        = (state_q == ST_RUN) & ~flush & ~load_use & if_id_valid;
  assign fsm_state   = state_q;

`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    rs1_sel = rs1_dout;
    rs2_sel = rs2_dout;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == dec_rs1)) rs1_sel = wb_data;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == dec_rs2)) rs2_sel = wb_data;
  end
`else
  // Register file resolves write-before-read itself; writeback port is not needed.
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_data, wb_reg_write};
  assign rs1_sel   = rs1_dout;
  assign rs2_sel   = rs2_dout;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (take && dec_is_halt) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halted  <= (state_d == ST_HALTED);
    end
  end

  // Reset, flush, load-use, drain/halt and empty decode all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || !take) begin
      id_ex_valid     <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_reg_write <= 1'b0;
      id_ex_pc        <= '0;
      id_ex_rs1_data  <= '0;
      id_ex_rs2_data  <= '0;
      id_ex_imm       <= '0;
      id_ex_rs1       <= '0;
      id_ex_rs2       <= '0;
      id_ex_rd        <= '0;
      id_ex_ctrl      <= '0;
    end else begin
      id_ex_valid     <= 1'b1;
      id_ex_mem_read  <= dec_mem_read;
      id_ex_reg_write <= dec_reg_write;
      id_ex_pc        <= if_id_pc;
      id_ex_rs1_data  <= rs1_sel;
      id_ex_rs2_data  <= rs2_sel;
      id_ex_imm       <= dec_imm;
      id_ex_rs1       <= dec_rs1;
      id_ex_rs2       <= dec_rs2;
      id_ex_rd        <= dec_rd;
      id_ex_ctrl      <= dec_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use, x0, flush, halt drain, writeback bypass.
module tb_id_ex_stage;

  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_id_valid;
  logic [31:0]       if_id_pc;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic              dec_use_rs1, dec_use_rs2;
  logic [31:0]       dec_imm;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_mem_read, dec_reg_write, dec_is_halt;
  logic [31:0]       rs1_dout, rs2_dout;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              wb_reg_write;
  logic              flush;
  logic              stall_if_id;
  logic              id_ex_valid, id_ex_mem_read, id_ex_reg_write;
  logic [31:0]       id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]        id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              halted;
  logic [1:0]        fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // clock/reset block
  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_imm(dec_imm),
    .dec_ctrl(dec_ctrl), .dec_mem_read(dec_mem_read), .dec_reg_write(dec_reg_write),
    .dec_is_halt(dec_is_halt), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write), .flush(flush),
    .stall_if_id(stall_if_id), .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1),
    .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_ctrl(id_ex_ctrl),
    .halted(halted), .fsm_state(fsm_state)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    if_id_valid = 0; if_id_pc = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_imm = 0; dec_ctrl = 0;
    dec_mem_read = 0; dec_reg_write = 0; dec_is_halt = 0;
    rs1_dout = 0; rs2_dout = 0; wb_rd = 0; wb_data = 0; wb_reg_write = 0; flush = 0;
  endtask

  task automatic drive_inst(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic mrd, input logic rw, input logic hlt);
    if_id_valid = 1; if_id_pc = pc; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_mem_read = mrd; dec_reg_write = rw;
    dec_is_halt = hlt; dec_ctrl = pc[15:0] ^ 16'hA5A5; dec_imm = ~pc;
  endtask

  task automatic test_reset();
    reset = 1;
    drive_inst(32'h40, 5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0);
    rs1_dout = 32'h1234; rs2_dout = 32'h5678;
    step(); step();
    vectors++; if (id_ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", id_ex_valid); end
    vectors++; if (id_ex_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", id_ex_pc); end
    vectors++; if (id_ex_ctrl !== 16'h0) begin miscompares++; $display("FAIL reset_ctrl got %h want 0", id_ex_ctrl); end
    vectors++; if (id_ex_rs1_data !== 32'h0 || id_ex_rd !== 5'd0 || id_ex_mem_read !== 1'b0) begin
      miscompares++; $display("FAIL reset_data got %h/%0d/%b want 0/0/0", id_ex_rs1_data, id_ex_rd, id_ex_mem_read); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
    vectors++; if (stall_if_id !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall_if_id); end
    reset = 0;
    clear_dec();
  endtask

  task automatic test_capture();
    drive_inst(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
    dec_imm = 32'hFFFF_FFF0; dec_ctrl = 16'h1234;
    rs1_dout = 32'h1111_1111; rs2_dout = 32'h2222_2222;
    #1;
    vectors++; if (stall_if_id !== 1'b0) begin miscompares++; $display("FAIL cap_stall got %b want 0", stall_if_id); end
    step();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_pc !== 32'h100) begin
      miscompares++; $display("FAIL cap_valid_pc got %b/%h want 1/00000100", id_ex_valid, id_ex_pc); end
    vectors++; if (id_ex_rs1_data !== 32'h1111_1111 || id_ex_rs2_data !== 32'h2222_2222) begin
      miscompares++; $display("FAIL cap_data got %h/%h want 11111111/22222222", id_ex_rs1_data, id_ex_rs2_data); end
    vectors++; if (id_ex_imm !== 32'hFFFF_FFF0 || id_ex_ctrl !== 16'h1234) begin
      miscompares++; $display("FAIL cap_imm_ctrl got %h/%h want fffffff0/1234", id_ex_imm, id_ex_ctrl); end
    vectors++; if (id_ex_rs1 !== 5'd1 || id_ex_rs2 !== 5'd2 || id_ex_rd !== 5'd3 || id_ex_reg_write !== 1'b1 || id_ex_mem_read !== 1'b0) begin
      miscompares++; $display("FAIL cap_idx got %0d/%0d/%0d rw%b mr%b want 1/2/3 rw1 mr0",
                              id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_write, id_ex_mem_read); end
    clear_dec();
    step();
    vectors++; if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 16'h0) begin
      miscompares++; $display("FAIL empty_slot got %b/%h want 0/0000", id_ex_valid, id_ex_ctrl); end
  endtask

  task automatic test_load_use();
    drive_inst(32'h200, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0);  // lw x5
    step();
    drive_inst(32'h204, 5'd5, 5'd1, 5'd6, 1, 1, 0, 1, 0);  // add x6,x5,x1
    rs1_dout = 32'h55; rs2_dout = 32'h11;
    #1;
    vectors++; if (stall_if_id !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", stall_if_id); end
    step();
    vectors++; if (id_ex_valid !== 1'b0 || id_ex_rd !== 5'd0 || id_ex_ctrl !== 16'h0 || id_ex_mem_read !== 1'b0) begin
      miscompares++; $display("FAIL lu_bubble got v%b rd%0d ctrl%h mr%b want v0 rd0 ctrl0 mr0",
                              id_ex_valid, id_ex_rd, id_ex_ctrl, id_ex_mem_read); end
    vectors++; if (stall_if_id !== 1'b0) begin miscompares++; $display("FAIL lu_stall_drop got %b want 0", stall_if_id); end
    step();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_pc !== 32'h204 || id_ex_rd !== 5'd6 || id_ex_rs1_data !== 32'h55) begin
      miscompares++; $display("FAIL lu_add got v%b pc%h rd%0d d%h want v1 pc00000204 rd6 d00000055",
                              id_ex_valid, id_ex_pc, id_ex_rd, id_ex_rs1_data); end
    // rs2 path, and a matching rs1 index that the instruction does not read
    drive_inst(32'h300, 5'd0, 5'd0, 5'd9, 0, 0, 1, 1, 0);  // lw x9
    step();
    drive_inst(32'h304, 5'd9, 5'd4, 5'd8, 0, 1, 0, 1, 0);
    #1;
    vectors++; if (stall_if_id !== 1'b0) begin miscompares++; $display("FAIL lu_unused_src got %b want 0", stall_if_id); end
    dec_rs2 = 5'd9;
    #1;
    vectors++; if (stall_if_id !== 1'b1) begin miscompares++; $display("FAIL lu_rs2 got %b want 1", stall_if_id); end
    clear_dec();
    step();
  endtask

  task automatic test_x0();
    drive_inst(32'h400, 5'd1, 5'd0, 5'd0, 1, 0, 1, 1, 0);  // lw x0
    step();
    drive_inst(32'h404, 5'd0, 5'd0, 5'd7, 1, 1, 0, 1, 0);
    rs1_dout = 32'h0000_0077;
    #1;
    vectors++; if (stall_if_id !== 1'b0) begin miscompares++; $display("FAIL x0_stall got %b want 0", stall_if_id); end
    step();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_rs1_data !== 32'h77) begin
      miscompares++; $display("FAIL x0_pass got v%b d%h want v1 d00000077", id_ex_valid, id_ex_rs1_data); end
    clear_dec();
  endtask

  task automatic test_flush();
    drive_inst(32'h500, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
    flush = 1;
    step();
    vectors++; if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 16'h0 || id_ex_pc !== 32'h0 || id_ex_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL flush_bubble got v%b ctrl%h pc%h rw%b want all 0", id_ex_valid, id_ex_ctrl, id_ex_pc, id_ex_reg_write); end
    drive_inst(32'h504, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);  // halt in decode, killed
    flush = 1;
    step();
    flush = 0;
    drive_inst(32'h600, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
    #1;
    vectors++; if (stall_if_id !== 1'b0 || fsm_state !== 2'd0) begin
      miscompares++; $display("FAIL flush_halt_run got stall%b st%0d want stall0 st0", stall_if_id, fsm_state); end
    step();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_pc !== 32'h600 || halted !== 1'b0) begin
      miscompares++; $display("FAIL flush_halt_next got v%b pc%h h%b want v1 pc00000600 h0", id_ex_valid, id_ex_pc, halted); end
    clear_dec();
  endtask

  task automatic test_halt_drain();
    drive_inst(32'h700, 5'd0, 5'd0, 5'd10, 0, 0, 0, 1, 1);  // ecall with reg_write decoded
    step();  // edge N
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_reg_write !== 1'b1 || id_ex_rd !== 5'd10) begin
      miscompares++; $display("FAIL halt_enter got v%b rw%b rd%0d want v1 rw1 rd10", id_ex_valid, id_ex_reg_write, id_ex_rd); end
    drive_inst(32'h704, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
    #1;
    vectors++; if (stall_if_id !== 1'b1 || halted !== 1'b0 || fsm_state !== 2'd1) begin
      miscompares++; $display("FAIL drain_stall got stall%b h%b st%0d want stall1 h0 st1", stall_if_id, halted, fsm_state); end
    flush = 1;
    step();  // N+1
    flush = 0;
    vectors++; if (id_ex_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++; $display("FAIL drain_n1 got v%b h%b want v0 h0", id_ex_valid, halted); end
    step();  // N+2
    vectors++; if (halted !== 1'b0 || stall_if_id !== 1'b1) begin
      miscompares++; $display("FAIL drain_n2 got h%b stall%b want h0 stall1", halted, stall_if_id); end
    step();  // N+3
    vectors++; if (halted !== 1'b1 || stall_if_id !== 1'b1 || id_ex_valid !== 1'b0) begin
      miscompares++; $display("FAIL halted_n3 got h%b stall%b v%b want h1 stall1 v0", halted, stall_if_id, id_ex_valid); end
    step(); step();
    vectors++; if (halted !== 1'b1 || id_ex_valid !== 1'b0 || fsm_state !== 2'd2) begin
      miscompares++; $display("FAIL halted_hold got h%b v%b st%0d want h1 v0 st2", halted, id_ex_valid, fsm_state); end
    reset = 1;
    step();
    reset = 0;
    vectors++; if (halted !== 1'b0 || fsm_state !== 2'd0 || id_ex_valid !== 1'b0 || stall_if_id !== 1'b0) begin
      miscompares++; $display("FAIL halt_reset got h%b st%0d v%b stall%b want 0/0/0/0", halted, fsm_state, id_ex_valid, stall_if_id); end
    step();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_pc !== 32'h704) begin
      miscompares++; $display("FAIL after_reset_cap got v%b pc%h want v1 pc00000704", id_ex_valid, id_ex_pc); end
    clear_dec();
    step();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs1, exp_rs2;
    drive_inst(32'h800, 5'd7, 5'd7, 5'd12, 1, 1, 0, 1, 0);
    rs1_dout = 32'h1; rs2_dout = 32'h2;
    wb_rd = 5'd7; wb_data = 32'hDEAD; wb_reg_write = 1;
`ifdef ID_EX_WB_BYPASS_EN
    exp_rs1 = 32'hDEAD; exp_rs2 = 32'hDEAD;
`else
    exp_rs1 = 32'h1; exp_rs2 = 32'h2;
`endif
    step();
    vectors++; if (id_ex_rs1_data !== exp_rs1 || id_ex_rs2_data !== exp_rs2) begin
      miscompares++; $display("FAIL bypass_hit got %h/%h want %h/%h", id_ex_rs1_data, id_ex_rs2_data, exp_rs1, exp_rs2); end
    // x0 writeback never forwards; non-matching index never forwards
    drive_inst(32'h804, 5'd0, 5'd3, 5'd12, 1, 1, 0, 1, 0);
    rs1_dout = 32'h0; rs2_dout = 32'h33;
    wb_rd = 5'd0; wb_data = 32'hBEEF; wb_reg_write = 1;
    step();
    vectors++; if (id_ex_rs1_data !== 32'h0 || id_ex_rs2_data !== 32'h33) begin
      miscompares++; $display("FAIL bypass_x0 got %h/%h want 00000000/00000033", id_ex_rs1_data, id_ex_rs2_data); end
    clear_dec();
  endtask

  initial begin
    clear_dec();
    reset = 1;
    test_reset();
    test_capture();
    test_load_use();
    test_x0();
    test_flush();
    test_halt_drain();
    test_bypass();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
